// File: rtl/fetch_bundle_sequencer_pkg.sv
// Shared definitions for the IF/DEC bundle sequencer: state encoding and
// slot geometry of the four-instruction fetch bundle.
package fetch_bundle_sequencer_pkg;

  localparam int SLOT_WIDTH = 2;
  localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = 2'd3;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ISSUE   = 2'd1,
    RECOVER = 2'd2
  } seq_state_e;

endpackage

// File: rtl/fetch_bundle_sequencer_bubble_counter.sv
// Saturating event counter used to accumulate decode bubble cycles.
module fetch_bundle_sequencer_bubble_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam logic [COUNT_WIDTH-1:0] ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  // Hold at all-ones instead of wrapping so a long stall stays visible.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {COUNT_WIDTH{1'b1}})) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_bundle_sequencer.sv
// Issues the held IF/DEC bundle one slot per cycle and owns the stall and
// flush controls of that pipeline register.
module fetch_bundle_sequencer
  import fetch_bundle_sequencer_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Bundle_Valid,
  input  logic [SLOT_WIDTH-1:0]  i_Start_Slot,
  input  logic                   i_Fetch_Ready,
  input  logic                   i_Hazard,
  input  logic                   i_Redirect,
  input  logic                   i_Mispredict,
  output logic                   o_Stall,
  output logic                   o_Flush,
  output logic [SLOT_WIDTH-1:0]  o_Slot,
  output logic                   o_Issue_Valid,
  output logic                   o_Fetch_Advance,
  output logic [COUNT_WIDTH-1:0] o_Bubble_Count
);

  seq_state_e            state_q, state_d;
  logic [SLOT_WIDTH-1:0] slot_q, slot_d;

  always_comb begin
    state_d         = state_q;
    slot_d          = slot_q;
    o_Issue_Valid   = 1'b0;
    o_Stall         = 1'b0;
    o_Flush         = !i_Fetch_Ready;
    o_Fetch_Advance = i_Fetch_Ready;

    if (i_Mispredict) begin
      // Stall must be low here: the register lets stall win over flush.
      o_Flush         = 1'b1;
      o_Fetch_Advance = 1'b0;
      state_d         = RECOVER;
      slot_d          = '0;
    end else if ((state_q == ISSUE) && i_Bundle_Valid) begin
      if (i_Hazard) begin
        o_Stall         = 1'b1;
        o_Flush         = 1'b0;
        o_Fetch_Advance = 1'b0;
      end else begin
        o_Issue_Valid = 1'b1;
        if ((slot_q == LAST_SLOT) || i_Redirect) begin
          if (i_Fetch_Ready) begin
            o_Flush         = 1'b0;
            o_Fetch_Advance = 1'b1;
            slot_d          = i_Start_Slot;
          end else begin
            o_Flush         = 1'b1;
            o_Fetch_Advance = 1'b0;
            state_d         = EMPTY;
          end
        end else begin
          o_Stall         = 1'b1;
          o_Flush         = 1'b0;
          o_Fetch_Advance = 1'b0;
          slot_d          = slot_q + 2'd1;
        end
      end
    end else begin
      // EMPTY, RECOVER and an invalid held bundle all wait for fetch.
      if (i_Fetch_Ready) begin
        state_d = ISSUE;
        slot_d  = i_Start_Slot;
      end else begin
        state_d = EMPTY;
      end
    end

    if (i_Reset) begin
      o_Issue_Valid   = 1'b0;
      o_Stall         = 1'b0;
      o_Flush         = !i_Fetch_Ready;
      o_Fetch_Advance = i_Fetch_Ready;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= EMPTY;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  assign o_Slot = slot_q;

  fetch_bundle_sequencer_bubble_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_bubble_counter (
    .clk   (i_Clk),
    .reset (i_Reset),
    .inc   (!o_Issue_Valid),
    .count (o_Bubble_Count)
  );

endmodule

// File: tb/tb_fetch_bundle_sequencer.sv
// Directed and randomized check of fetch_bundle_sequencer against a
// remaining-instruction model of the held bundle.
module tb_fetch_bundle_sequencer;

  logic        clk = 1'b0;
  logic        rst, bundle_valid, fetch_ready, hazard, redirect, mispredict;
  logic [1:0]  start_slot;
  logic        stall, flush, issue_valid, fetch_advance;
  logic [1:0]  slot;
  logic [15:0] bubble_count;

  int vectors = 0;
  int miscompares = 0;

  // Model: slot being presented, instructions left in the held bundle
  // (0 means nothing to issue), and the bubble tally.
  int m_slot  = 0;
  int m_left  = 0;
  int m_count = 0;
  bit m_known = 1'b0;

  always #5 clk = ~clk;

  fetch_bundle_sequencer #(.COUNT_WIDTH(16)) dut (
    .i_Clk           (clk),
    .i_Reset         (rst),
    .i_Bundle_Valid  (bundle_valid),
    .i_Start_Slot    (start_slot),
    .i_Fetch_Ready   (fetch_ready),
    .i_Hazard        (hazard),
    .i_Redirect      (redirect),
    .i_Mispredict    (mispredict),
    .o_Stall         (stall),
    .o_Flush         (flush),
    .o_Slot          (slot),
    .o_Issue_Valid   (issue_valid),
    .o_Fetch_Advance (fetch_advance),
    .o_Bubble_Count  (bubble_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic bv, input logic [1:0] ss,
                               input logic rdy, input logic hz, input logic rd, input logic mp);
    logic e_issue, e_stall, e_flush, e_adv;
    int   n_slot, n_left, n_count;
    bit   busy;
    @(negedge clk);
    rst = r; bundle_valid = bv; start_slot = ss;
    fetch_ready = rdy; hazard = hz; redirect = rd; mispredict = mp;

    busy    = (m_left > 0) && bv;
    n_slot  = m_slot;
    n_left  = m_left;
    n_count = m_count;
    e_issue = 1'b0; e_stall = 1'b0; e_flush = !rdy; e_adv = rdy;
    if (r) begin
      n_slot = 0; n_left = 0; n_count = 0;
    end else if (mp) begin
      e_flush = 1'b1; e_adv = 1'b0; n_slot = 0; n_left = 0;
    end else if (!busy) begin
      if (rdy) begin n_slot = ss; n_left = 4 - ss; end
      else n_left = 0;
    end else if (hz) begin
      e_stall = 1'b1; e_flush = 1'b0; e_adv = 1'b0;
    end else if (m_left == 1 || rd) begin
      e_issue = 1'b1;
      if (rdy) begin e_flush = 1'b0; e_adv = 1'b1; n_slot = ss; n_left = 4 - ss; end
      else begin e_flush = 1'b1; e_adv = 1'b0; n_left = 0; end
    end else begin
      e_issue = 1'b1; e_stall = 1'b1; e_flush = 1'b0; e_adv = 1'b0;
      n_slot = m_slot + 1; n_left = m_left - 1;
    end
    if (!r && !e_issue && m_count < 65535) n_count = m_count + 1;

    #1;
    vectors++;
    checkOutput("issue_valid", 32'(issue_valid), 32'(e_issue));
    checkOutput("stall", 32'(stall), 32'(e_stall));
    checkOutput("flush", 32'(flush), 32'(e_flush));
    checkOutput("fetch_advance", 32'(fetch_advance), 32'(e_adv));
    if (m_known) begin
      checkOutput("slot", 32'(slot), 32'(m_slot));
      checkOutput("bubble_count", 32'(bubble_count), 32'(m_count));
    end

    @(posedge clk);
    m_slot  = n_slot;
    m_left  = n_left;
    m_count = n_count;
    if (r) m_known = 1'b1;
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; bundle_valid = 1'b0; start_slot = 2'd0;
    fetch_ready = 1'b0; hazard = 1'b0; redirect = 1'b0; mispredict = 1'b0;

    // Two back-to-back bundles from slot 0 with fetch always ready.
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, 1, 0, 0, 0);
    #1 checkOutput("bubbles_two_bundles", 32'(bubble_count), 32'd1);

    // Bundle starting at slot 2, then fetch dries up.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 2, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 2, 0, 0, 0, 0);

    // Hazard held three cycles at slot 1, redirect ignored meanwhile.
    doReset();
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 1, i == 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 1, 0, 0, 0);

    // Redirect at slot 1 with fetch ready, then redirect on slot 3.
    doReset();
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 1, 0);

    // Mispredict together with hazard at slot 2.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 1, 0, 1);
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 1, 0, 0, 0);

    // Bubble counter saturation, then reset mid-bundle.
    doReset();
    for (int i = 0; i < 70000; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("bubble_saturated", 32'(bubble_count), 32'hFFFF);
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    #1 checkOutput("slot_after_mid_reset", 32'(slot), 32'd0);
    checkOutput("bubbles_after_mid_reset", 32'(bubble_count), 32'd0);

    // Randomized traffic.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(63) == 0,
                    $urandom_range(7) != 0,
                    2'($urandom_range(3)),
                    $urandom_range(3) != 0,
                    $urandom_range(4) == 0,
                    $urandom_range(7) == 0,
                    $urandom_range(15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
